food_spawn_ctrl: RTL
====================

# food_spawn_ctrl

Sequences the shared random-sequence generator to place the apple on the snake grid. On a spawn request it waits for fresh random bits, draws an X and then a Y coordinate, and rejects out-of-grid values. It then queries the snake occupancy map and retries on collision, publishing the accepted cell to the renderer and collision logic. It sits between the game FSM, the random generator and the body-occupancy RAM.

## Interface
- GRID_W, 32: grid columns; X valid range 0..GRID_W-1
- GRID_H, 24: grid rows; Y valid range 0..GRID_H-1
- SAMPLE_GAP, 7: cycles between consecutive random samples; the generator refreshes 1 bit per cycle, so 7 gives a fully new 7-bit word
- MAX_TRIES, 64: rejected draws allowed before giving up or falling back
- INIT_X, 20 / INIT_Y, 12: food position at reset
- clock_25  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- spawn_req  in  1  one-cycle request from the game FSM (apple eaten / new game)
- rnd  in  7  random word from the random-sequence generator
- occ_rd  out  1  occupancy read strobe
- occ_x  out  7  occupancy query column
- occ_y  out  7  occupancy query row
- occ_hit  in  1  occupancy result, valid the cycle after occ_rd (registered RAM read)
- food_x  out  7  current food column
- food_y  out  7  current food row
- food_valid  out  1  food present on grid
- busy  out  1  placement in progress
- done  out  1  one-cycle pulse: new position committed
- fail  out  1  one-cycle pulse: no position found

## Operation
- Reset values: food_x=INIT_X, food_y=INIT_Y, food_valid=1, busy=0, done=0, fail=0, occ_rd=0, occ_x=0, occ_y=0, internal pending=0, tries=0, state=IDLE.
- States: IDLE, GAP_X, GAP_Y, QUERY, CHECK, COMMIT, FAIL, plus SCAN_Q and SCAN_C when fallback is enabled.
- IDLE: spawn_req=1 moves to GAP_X and clears tries. From the next cycle, food_valid=0 and busy=1.
- GAP_X: count SAMPLE_GAP cycles and latch rnd on the last one.
  - rnd >= GRID_W: tries++, restart GAP_X.
  - Otherwise go to GAP_Y.
- GAP_Y: same as GAP_X against GRID_H. Out-of-range Y restarts at GAP_X with tries++.
- QUERY: occ_rd=1 for one cycle, with occ_x/occ_y driving the candidate cell.
- CHECK: sample occ_hit.
  - occ_hit=1: tries++, go to GAP_X.
  - occ_hit=0: go to COMMIT.
- COMMIT: load food_x/food_y, food_valid=1, done=1, busy=0, then return to IDLE.
- Try exhaustion: reaching tries==MAX_TRIES at any rejection goes to FAIL, or to the scan when the fallback is enabled.
- FAIL: fail=1 for one cycle, food_valid stays 0, food_x/food_y unchanged, then IDLE.
- spawn_req while busy sets pending; further requests while pending are dropped. In IDLE, pending=1 is treated exactly as spawn_req=1 and clears pending.
- spawn_req in the same cycle as COMMIT or FAIL sets pending. The new placement starts the cycle after IDLE is entered.
- Reset at any point, including mid-query: return to reset values immediately; in-flight occ_hit is ignored.

## Timing
- Request accepted in cycle 0; GAP_X spans cycles 1..G (G=SAMPLE_GAP).
- X sampled in cycle G, Y sampled in cycle 2G.
- QUERY in 2G+1, CHECK in 2G+2, COMMIT in 2G+3.
- Best case with G=7: done=1 and the new food_x/food_y in cycle 17.
- Each X/Y/range rejection costs G cycles per redrawn coordinate. Each occupancy rejection costs 2G+2 cycles.
- occ_rd is high for exactly one cycle per query. occ_x/occ_y are held stable through QUERY and CHECK.

## Configuration
- FOOD_FALLBACK_SCAN_EN defined: on try exhaustion, scan the grid row-major from (0,0).
  - Each cell costs 2 cycles (SCAN_Q strobe, SCAN_C check).
  - The first free cell goes to COMMIT.
  - A fully occupied grid (GRID_W*GRID_H hits) goes to FAIL.
- Not defined: exhaustion goes straight to FAIL, and the scan states and logic are absent.

## Structure
- Shared snake_game_pkg holds:
  - the state enum
  - GRID_W/GRID_H defaults
  - the 7-bit coordinate width constant, shared with the renderer and collision logic
- One natural sub-module: food_scan_iter, the row-major X/Y iterator with wrap and last-cell flag. It is instantiated only under FOOD_FALLBACK_SCAN_EN.

## Test plan
- Valid, free draw: spawn_req in cycle 0, rnd=10 at cycle 7, rnd=5 at cycle 14, occ_hit=0 -> occ_rd in cycle 15 with (10,5); done and food=(10,5) in cycle 17.
- Out-of-range X: rnd=40 at cycle 7, then 3 at 14, 4 at 21, occ_hit=0 -> tries=1, done at cycle 24 with food=(3,4).
- Collision: first candidate (10,5) gets occ_hit=1 and the second (11,5) is free -> done at cycle 33 with food=(11,5).
- Occupancy hit on every query, no macro -> fail pulse after 64 tries, food_valid=0, food_x/y unchanged. With the macro and only (31,23) free -> done with food=(31,23).
- spawn_req at cycle 5 while busy -> first done at 17, second placement accepted at 18, second done at 35.
- Reset asserted at cycle 15 -> next cycle food=(20,12), food_valid=1, busy=0, no done/fail pulse.

Source files
------------

// File: rtl/snake_game_pkg.sv
// Shared snake-game types: FSM state encoding, grid defaults and the coordinate width.
// FOOD_FALLBACK_SCAN_EN adds the two scan states used by the food placement fallback.
package snake_game_pkg;

    localparam int COORD_W    = 7;
    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;

    typedef logic [COORD_W-1:0] coord_t;

`ifdef FOOD_FALLBACK_SCAN_EN
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GAP_X,
        ST_GAP_Y,
        ST_QUERY,
        ST_CHECK,
        ST_COMMIT,
        ST_FAIL,
        ST_SCAN_Q,
        ST_SCAN_C
    } food_state_e;
`else
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GAP_X,
        ST_GAP_Y,
        ST_QUERY,
        ST_CHECK,
        ST_COMMIT,
        ST_FAIL
    } food_state_e;
`endif

endpackage

// File: rtl/food_spawn_ctrl_if.sv
// Request, random-word, occupancy-RAM and food-position signals of the food placer.
// master = game FSM / RNG / occupancy RAM side, slave = food_spawn_ctrl.
interface food_spawn_ctrl_if;
    import snake_game_pkg::*;

    logic   spawn_req;
    coord_t rnd;
    logic   occ_rd;
    coord_t occ_x;
    coord_t occ_y;
    logic   occ_hit;
    coord_t food_x;
    coord_t food_y;
    logic   food_valid;
    logic   busy;
    logic   done;
    logic   fail;

    modport master (
        output spawn_req, rnd, occ_hit,
        input  occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail
    );

    modport slave (
        input  spawn_req, rnd, occ_hit,
        output occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail
    );

endinterface

// File: rtl/food_scan_iter.sv
// Row-major grid walker for the fallback scan: current cell, the cell after it, and a
// last-cell flag. Only instantiated when FOOD_FALLBACK_SCAN_EN is defined.
module food_scan_iter
    import snake_game_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic   clock_25,
    input  logic   reset,
    input  logic   clr,
    input  logic   adv,
    output coord_t x,
    output coord_t y,
    output coord_t nxt_x,
    output coord_t nxt_y,
    output logic   last
);

    localparam coord_t X_MAX = coord_t'(GRID_W - 1);
    localparam coord_t Y_MAX = coord_t'(GRID_H - 1);

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   row_end;

    always_comb begin
        row_end = (x_q == X_MAX);
        last    = row_end && (y_q == Y_MAX);
        nxt_x   = row_end ? '0 : x_q + coord_t'(1);
        nxt_y   = row_end ? (last ? '0 : y_q + coord_t'(1)) : y_q;
        x_d     = x_q;
        y_d     = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            x_d = nxt_x;
            y_d = nxt_y;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/food_spawn_ctrl.sv
// Apple placement: draws X then Y from the shared RNG, range-checks, queries occupancy and
// retries on collision. FOOD_FALLBACK_SCAN_EN adds a row-major scan after MAX_TRIES rejections.
//
// state     | meaning
// IDLE      | waiting for spawn_req or a pending request
// GAP_X     | letting SAMPLE_GAP fresh random bits accumulate, then sample X
// GAP_Y     | same for Y
// QUERY     | occupancy read strobe for the candidate cell
// CHECK     | occ_hit valid; accept or reject
// COMMIT    | new food position published, done pulse
// FAIL      | no position found, fail pulse
// SCAN_Q    | fallback scan: strobe current grid cell
// SCAN_C    | fallback scan: check current grid cell
module food_spawn_ctrl
    import snake_game_pkg::*;
#(
    parameter int GRID_W     = GRID_W_DEF,
    parameter int GRID_H     = GRID_H_DEF,
    parameter int SAMPLE_GAP = 7,
    parameter int MAX_TRIES  = 64,
    parameter int INIT_X     = 20,
    parameter int INIT_Y     = 12
) (
    input  logic             clock_25,
    input  logic             reset,
    food_spawn_ctrl_if.slave bus
);

    localparam int GAP_W = $clog2(SAMPLE_GAP + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SAMPLE_GAP - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam coord_t GRID_W_C = coord_t'(GRID_W);
    localparam coord_t GRID_H_C = coord_t'(GRID_H);

    food_state_e      state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             pending_q, pending_d;
    coord_t           cand_x_q, cand_x_d;
    coord_t           occ_x_q, occ_x_d;
    coord_t           occ_y_q, occ_y_d;
    coord_t           food_x_q, food_x_d;
    coord_t           food_y_q, food_y_d;
    logic             food_valid_q, food_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             occ_rd_q, occ_rd_d;
    logic             reject;
    logic             scan_clr;
    logic             scan_adv;

`ifdef FOOD_FALLBACK_SCAN_EN
    coord_t scan_x, scan_y, scan_nxt_x, scan_nxt_y;
    logic   scan_last;

    food_scan_iter #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_scan (
        .clock_25 (clock_25),
        .reset    (reset),
        .clr      (scan_clr),
        .adv      (scan_adv),
        .x        (scan_x),
        .y        (scan_y),
        .nxt_x    (scan_nxt_x),
        .nxt_y    (scan_nxt_y),
        .last     (scan_last)
    );
`endif

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        tries_d      = tries_q;
        pending_d    = pending_q;
        cand_x_d     = cand_x_q;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        reject       = 1'b0;
        scan_clr     = 1'b0;
        scan_adv     = 1'b0;

        if (bus.spawn_req && (state_q != ST_IDLE))
            pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.spawn_req || pending_q) begin
                    state_d      = ST_GAP_X;
                    gap_d        = GAP_LOAD;
                    tries_d      = '0;
                    pending_d    = 1'b0;
                    food_valid_d = 1'b0;
                    scan_clr     = 1'b1;
                end
            end
            ST_GAP_X: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (bus.rnd >= GRID_W_C) begin
                    reject = 1'b1;
                end else begin
                    cand_x_d = bus.rnd;
                    state_d  = ST_GAP_Y;
                    gap_d    = GAP_LOAD;
                end
            end
            ST_GAP_Y: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (bus.rnd >= GRID_H_C) begin
                    reject = 1'b1;
                end else begin
                    occ_x_d = cand_x_q;
                    occ_y_d = bus.rnd;
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: state_d = ST_CHECK;
            ST_CHECK: begin
                if (bus.occ_hit) begin
                    reject = 1'b1;
                end else begin
                    state_d      = ST_COMMIT;
                    food_x_d     = occ_x_q;
                    food_y_d     = occ_y_q;
                    food_valid_d = 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_FAIL:   state_d = ST_IDLE;
`ifdef FOOD_FALLBACK_SCAN_EN
            ST_SCAN_Q: state_d = ST_SCAN_C;
            ST_SCAN_C: begin
                if (!bus.occ_hit) begin
                    state_d      = ST_COMMIT;
                    food_x_d     = occ_x_q;
                    food_y_d     = occ_y_q;
                    food_valid_d = 1'b1;
                end else if (scan_last) begin
                    state_d = ST_FAIL;
                end else begin
                    scan_adv = 1'b1;
                    occ_x_d  = scan_nxt_x;
                    occ_y_d  = scan_nxt_y;
                    state_d  = ST_SCAN_Q;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // every rejection (range or collision) counts toward exhaustion
        if (reject) begin
            tries_d = tries_q + TRY_W'(1);
            if (tries_d == TRY_MAX) begin
`ifdef FOOD_FALLBACK_SCAN_EN
                state_d = ST_SCAN_Q;
                occ_x_d = scan_x;
                occ_y_d = scan_y;
`else
                state_d = ST_FAIL;
`endif
            end else begin
                state_d = ST_GAP_X;
                gap_d   = GAP_LOAD;
            end
        end

        occ_rd_d = (state_d == ST_QUERY);
`ifdef FOOD_FALLBACK_SCAN_EN
        if (state_d == ST_SCAN_Q)
            occ_rd_d = 1'b1;
`endif
        done_d = (state_d == ST_COMMIT);
        fail_d = (state_d == ST_FAIL);
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_COMMIT) || (state_d == ST_FAIL));
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            tries_q      <= '0;
            pending_q    <= 1'b0;
            cand_x_q     <= '0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_x_q     <= coord_t'(INIT_X);
            food_y_q     <= coord_t'(INIT_Y);
            food_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            occ_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            tries_q      <= tries_d;
            pending_q    <= pending_d;
            cand_x_q     <= cand_x_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            occ_rd_q     <= occ_rd_d;
        end
    end

    assign bus.occ_rd     = occ_rd_q;
    assign bus.occ_x      = occ_x_q;
    assign bus.occ_y      = occ_y_q;
    assign bus.food_x     = food_x_q;
    assign bus.food_y     = food_y_q;
    assign bus.food_valid = food_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;

endmodule
